fp_div_pipe: RTL and testbench

// - Parametrised, fully pipelined IEEE-754 single-precision divider (a / b), native RTL.
// - Drop-in successor to the fixed-latency vendor divider core used by the classifier datapath. Adds:
//   - tready backpressure
//   - tag passthrough
//   - exception flags
//   - latency selectable via quotient bits per stage
// - Accepts one operation per cycle when not stalled.

---
 rtl/fp_div_pkg.sv | 39 +++
 rtl/fp_div_stage.sv | 67 ++++++
 rtl/fp_div_pipe.sv | 199 +++++++++++++++++++
 tb/tb_fp_div_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the pipelined FP32 divider.
package fp_div_pkg;

    localparam int unsigned NQ    = 25;  // quotient bits: 24 mantissa + guard
    localparam int unsigned MW    = 24;  // mantissa width including hidden bit
    localparam int unsigned RW    = 26;  // partial remainder width
    localparam int unsigned EW    = 10;  // signed working exponent width
    localparam int unsigned FLG_W = 4;

    localparam int unsigned FLG_INV = 3;
    localparam int unsigned FLG_DZ  = 2;
    localparam int unsigned FLG_OVF = 1;
    localparam int unsigned FLG_UNF = 0;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [30:0] FP32_INF_MAG = 31'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        NORMAL,
        QNAN,
        INF,
        ZERO
    } spec_t;

    // Side-band that travels alongside the remainder through every stage
    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        spec_t         code;
        logic          dz;
    } side_t;

endpackage

// File: rtl/fp_div_stage.sv
// One pipeline stage of NB restoring-division iterations with delay-matched side-band.
module fp_div_stage
    import fp_div_pkg::*;
#(
    parameter int unsigned TAG_W = 8,
    parameter int unsigned NB    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             src_valid,
    input  side_t            src_sb,
    input  logic [TAG_W-1:0] src_tag,
    input  logic [RW-1:0]    src_rem,
    input  logic [NQ-1:0]    src_quo,
    input  logic [MW-1:0]    src_dsr,
    output logic             valid,
    output side_t            sb,
    output logic [TAG_W-1:0] tag,
    output logic [RW-1:0]    rem,
    output logic [NQ-1:0]    quo,
    output logic [MW-1:0]    dsr
);

    localparam int unsigned TW = RW + 1;

    logic [RW-1:0] rem_n;
    logic [NQ-1:0] quo_n;
    logic [TW-1:0] trial;

    // Trial-subtract, keep or restore, then shift; one quotient bit per iteration
    always_comb begin
        rem_n = src_rem;
        quo_n = src_quo;
        trial = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            trial = {1'b0, rem_n} - TW'(src_dsr);
            if (!trial[TW-1]) begin
                rem_n = trial[RW-1:0];
                quo_n = {quo_n[NQ-2:0], 1'b1};
            end else begin
                quo_n = {quo_n[NQ-2:0], 1'b0};
            end
            rem_n = {rem_n[RW-2:0], 1'b0};
        end
    end

    // Stage register; holds when the pipe is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            sb    <= '0;
            tag   <= '0;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
        end else if (adv) begin
            valid <= src_valid;
            sb    <= src_sb;
            tag   <= src_tag;
            rem   <= rem_n;
            quo   <= quo_n;
            dsr   <= src_dsr;
        end
    end

endmodule

// File: rtl/fp_div_pipe.sv
// Fully pipelined FP32 divider: unpack, NSTAGE restoring stages, round/pack.
// Accept-to-result latency is NSTAGE+2 cycles when the output is not stalled.
module fp_div_pipe
    import fp_div_pkg::*;
#(
    parameter int unsigned TAG_W          = 8,
    parameter int unsigned BITS_PER_STAGE = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [31:0]      s_axis_a_tdata,
    input  logic [31:0]      s_axis_b_tdata,
    input  logic [TAG_W-1:0] s_axis_tuser,
    output logic             m_axis_result_tvalid,
    input  logic             m_axis_result_tready,
    output logic [31:0]      m_axis_result_tdata,
    output logic [TAG_W-1:0] m_axis_result_tuser,
    output logic [FLG_W-1:0] m_axis_result_tflags
);

    localparam int unsigned NSTAGE = (NQ + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    localparam int unsigned MRW    = MW + 1;
    localparam logic signed [EW-1:0] E_SAT  = EW'(255);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    logic adv;

    fp32_t         fa, fb;
    logic          a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [MW-1:0] ma, mb;
    logic          shift;
    side_t         side_n;
    logic [RW-1:0] rem0;

    logic             u_valid;
    side_t            u_sb;
    logic [TAG_W-1:0] u_tag;
    logic [RW-1:0]    u_rem;
    logic [MW-1:0]    u_dsr;

    logic             v_a   [NSTAGE+1];
    side_t            sb_a  [NSTAGE+1];
    logic [TAG_W-1:0] tag_a [NSTAGE+1];
    logic [RW-1:0]    rem_a [NSTAGE+1];
    logic [NQ-1:0]    quo_a [NSTAGE+1];
    logic [MW-1:0]    dsr_a [NSTAGE+1];

    side_t             sb_l;
    logic [MW-1:0]     mant;
    logic              rup;
    logic [MRW-1:0]    mant_r;
    logic [22:0]       frac;
    logic signed [EW-1:0] e_s;
    logic [31:0]       res_n;
    logic [FLG_W-1:0]  flg_n;

    // Whole pipe advances together unless a valid result is being held
    assign adv           = !m_axis_result_tvalid || m_axis_result_tready;
    assign s_axis_tready = adv;

    assign fa = fp32_t'(s_axis_a_tdata);
    assign fb = fp32_t'(s_axis_b_tdata);

    // Classify operands (denormals flush to zero), prenormalise, pick special code
    always_comb begin
        a_zero = (fa.exp == 8'h00);
        b_zero = (fb.exp == 8'h00);
        a_inf  = (fa.exp == 8'hFF) && (fa.man == '0);
        b_inf  = (fb.exp == 8'hFF) && (fb.man == '0);
        a_nan  = (fa.exp == 8'hFF) && (fa.man != '0);
        b_nan  = (fb.exp == 8'hFF) && (fb.man != '0);
        ma     = {1'b1, fa.man};
        mb     = {1'b1, fb.man};
        shift  = (ma < mb);
        rem0   = shift ? RW'({ma, 1'b0}) : RW'(ma);

        side_n      = '0;
        side_n.sign = fa.sign ^ fb.sign;
        side_n.exp  = EW'(fa.exp) - EW'(fb.exp) + EW'(127) - EW'(shift);
        side_n.code = NORMAL;
        side_n.dz   = 1'b0;
        if (a_nan || b_nan) begin
            side_n.code = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            side_n.code = QNAN;
        end else if (b_zero && !a_inf) begin
            side_n.code = INF;
            side_n.dz   = 1'b1;
        end else if (a_inf) begin
            side_n.code = INF;
        end else if (a_zero || b_inf) begin
            side_n.code = ZERO;
        end
    end

    // Unpack register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            u_valid <= 1'b0;
            u_sb    <= '0;
            u_tag   <= '0;
            u_rem   <= '0;
            u_dsr   <= '0;
        end else if (adv) begin
            u_valid <= s_axis_tvalid;
            u_sb    <= side_n;
            u_tag   <= s_axis_tuser;
            u_rem   <= rem0;
            u_dsr   <= mb;
        end
    end

    assign v_a[0]   = u_valid;
    assign sb_a[0]  = u_sb;
    assign tag_a[0] = u_tag;
    assign rem_a[0] = u_rem;
    assign quo_a[0] = '0;
    assign dsr_a[0] = u_dsr;

    // Divide stages; the last one takes whatever quotient bits remain
    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        localparam int unsigned NB = (g == NSTAGE - 1) ?
                                     NQ - (NSTAGE - 1) * BITS_PER_STAGE : BITS_PER_STAGE;
        fp_div_stage #(
            .TAG_W (TAG_W),
            .NB    (NB)
        ) u_stage (
            .clk       (aclk),
            .rst_n     (aresetn),
            .adv       (adv),
            .src_valid (v_a[g]),
            .src_sb    (sb_a[g]),
            .src_tag   (tag_a[g]),
            .src_rem   (rem_a[g]),
            .src_quo   (quo_a[g]),
            .src_dsr   (dsr_a[g]),
            .valid     (v_a[g+1]),
            .sb        (sb_a[g+1]),
            .tag       (tag_a[g+1]),
            .rem       (rem_a[g+1]),
            .quo       (quo_a[g+1]),
            .dsr       (dsr_a[g+1])
        );
    end

    // Round to nearest even, renormalise on carry, saturate exponent range
    always_comb begin
        sb_l   = sb_a[NSTAGE];
        mant   = quo_a[NSTAGE][NQ-1:1];
        rup    = quo_a[NSTAGE][0] && ((|rem_a[NSTAGE]) || mant[0]);
        mant_r = {1'b0, mant} + MRW'(rup);
        frac   = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MW-2:0];
        e_s    = $signed(sb_l.exp + EW'(mant_r[MW]));
        res_n  = '0;
        flg_n  = '0;
        case (sb_l.code)
            QNAN: begin
                res_n          = FP32_QNAN;
                flg_n[FLG_INV] = 1'b1;
            end
            INF: begin
                res_n         = {sb_l.sign, FP32_INF_MAG};
                flg_n[FLG_DZ] = sb_l.dz;
            end
            ZERO: begin
                res_n = {sb_l.sign, 31'b0};
            end
            default: begin
                if (e_s >= E_SAT) begin
                    res_n          = {sb_l.sign, FP32_INF_MAG};
                    flg_n[FLG_OVF] = 1'b1;
                end else if (e_s <= E_ZERO) begin
                    res_n          = {sb_l.sign, 31'b0};
                    flg_n[FLG_UNF] = 1'b1;
                end else begin
                    res_n = {sb_l.sign, e_s[7:0], frac};
                end
            end
        endcase
    end

    // Output register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
            m_axis_result_tuser  <= '0;
            m_axis_result_tflags <= '0;
        end else if (adv) begin
            m_axis_result_tvalid <= v_a[NSTAGE];
            m_axis_result_tdata  <= res_n;
            m_axis_result_tuser  <= tag_a[NSTAGE];
            m_axis_result_tflags <= flg_n;
        end
    end

endmodule

// File: tb/tb_fp_div_pipe.sv
// Directed scoreboard bench for fp_div_pipe (default and BITS_PER_STAGE=3 instances).
module tb_fp_div_pipe;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic [3:0]  flags;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic        s_valid, s_ready;
    logic [31:0] s_a, s_b;
    logic [7:0]  s_tag;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic [7:0]  m_tag;
    logic [3:0]  m_flags;

    logic        s3_valid, s3_ready;
    logic [31:0] s3_a, s3_b;
    logic [7:0]  s3_tag;
    logic        m3_valid, m3_ready;
    logic [31:0] m3_data;
    logic [7:0]  m3_tag;
    logic [3:0]  m3_flags;

    exp_t sbq[$];
    int   n_pass    = 0;
    int   n_total   = 0;
    int   out_count = 0;

    always #5 aclk = ~aclk;

    fp_div_pipe dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_tvalid        (s_valid),
        .s_axis_tready        (s_ready),
        .s_axis_a_tdata       (s_a),
        .s_axis_b_tdata       (s_b),
        .s_axis_tuser         (s_tag),
        .m_axis_result_tvalid (m_valid),
        .m_axis_result_tready (m_ready),
        .m_axis_result_tdata  (m_data),
        .m_axis_result_tuser  (m_tag),
        .m_axis_result_tflags (m_flags)
    );

    fp_div_pipe #(.TAG_W(8), .BITS_PER_STAGE(3)) dut3 (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_tvalid        (s3_valid),
        .s_axis_tready        (s3_ready),
        .s_axis_a_tdata       (s3_a),
        .s_axis_b_tdata       (s3_b),
        .s_axis_tuser         (s3_tag),
        .m_axis_result_tvalid (m3_valid),
        .m_axis_result_tready (m3_ready),
        .m_axis_result_tdata  (m3_data),
        .m_axis_result_tuser  (m3_tag),
        .m_axis_result_tflags (m3_flags)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    endtask

    // Scoreboard: every handshaken result must match the oldest expectation
    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            out_count++;
            check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                check($sformatf("res_tag exp%0h", e.tag), 64'(m_tag), 64'(e.tag));
                check($sformatf("res_data tag%0h", e.tag), 64'(m_data), 64'(e.data));
                check($sformatf("res_flags tag%0h", e.tag), 64'(m_flags), 64'(e.flags));
            end
        end
    end

    // Present one operation, wait for acceptance, record the expected result
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                         input logic [31:0] ed, input logic [3:0] ef);
        exp_t e;
        int   g;
        s_a     = a;
        s_b     = b;
        s_tag   = tag;
        s_valid = 1'b1;
        g       = 0;
        while (!s_ready && g < 200) begin
            @(posedge aclk); #1;
            g++;
        end
        if (g >= 200) check("issue_timeout", 64'(s_ready), 64'd1);
        e.data  = ed;
        e.tag   = tag;
        e.flags = ef;
        sbq.push_back(e);
        @(posedge aclk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(posedge aclk); #1;
            g++;
        end
        check(name, 64'(sbq.size()), 64'd0);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 1;
        while (!m_valid && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        check(name, 64'(m_valid), 64'd1);
    endtask

    // Single operation on the 3-bits-per-stage instance with latency check
    task automatic run3(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                        input logic [31:0] ed, input string name);
        int n;
        check({name, "_s_ready"}, 64'(s3_ready), 64'd1);
        s3_a     = a;
        s3_b     = b;
        s3_tag   = tag;
        s3_valid = 1'b1;
        @(posedge aclk); #1;
        s3_valid = 1'b0;
        n = 1;
        while (!m3_valid && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd11);
        check({name, "_data"}, 64'(m3_data), 64'(ed));
        check({name, "_tag"}, 64'(m3_tag), 64'(tag));
        check({name, "_flags"}, 64'(m3_flags), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int oc;
        aresetn  = 1'b0;
        s_valid  = 1'b0; s_a = '0; s_b = '0; s_tag = '0; m_ready = 1'b1;
        s3_valid = 1'b0; s3_a = '0; s3_b = '0; s3_tag = '0; m3_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_valid), 64'd0);
        check("rst_tdata",  64'(m_data),  64'd0);
        check("rst_tuser",  64'(m_tag),   64'd0);
        check("rst_tflags", 64'(m_flags), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("idle_s_ready", 64'(s_ready), 64'd1);

        // 6/2 with exact latency
        issue(32'h40C00000, 32'h40000000, 8'hA0, 32'h40400000, 4'b0000);
        wait_valid("lat_valid", n);
        check("latency_bps1", 64'(n), 64'd27);
        drain("drain_basic");

        // Rounding, specials and range limits, back to back
        issue(32'h3F800000, 32'h40400000, 8'hA1, 32'h3EAAAAAB, 4'b0000);
        issue(32'h3F800000, 32'h00000000, 8'hA2, 32'h7F800000, 4'b0100);
        issue(32'h80000000, 32'h00000000, 8'hA3, 32'h7FC00000, 4'b1000);
        issue(32'h7F800000, 32'hC0000000, 8'hA4, 32'hFF800000, 4'b0000);
        issue(32'h7F7FFFFF, 32'h00800000, 8'hA5, 32'h7F800000, 4'b0010);
        issue(32'h00800000, 32'h40000000, 8'hA6, 32'h00000000, 4'b0001);
        issue(32'h7FC00001, 32'h3F800000, 8'hA7, 32'h7FC00000, 4'b1000);
        issue(32'h7F800000, 32'h00000000, 8'hA8, 32'h7F800000, 4'b0000);
        drain("drain_specials");

        // Backpressure: stall the first result for 10 cycles
        m_ready = 1'b0;
        oc = out_count;
        issue(32'h40C00000, 32'h40000000, 8'd1, 32'h40400000, 4'b0000);
        issue(32'h3F800000, 32'h40400000, 8'd2, 32'h3EAAAAAB, 4'b0000);
        issue(32'h3F800000, 32'h00000000, 8'd3, 32'h7F800000, 4'b0100);
        issue(32'h7F800000, 32'hC0000000, 8'd4, 32'hFF800000, 4'b0000);
        issue(32'h00800000, 32'h40000000, 8'd5, 32'h00000000, 4'b0001);
        wait_valid("bp_first_valid", n);
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk); #1;
            check($sformatf("bp_tvalid c%0d", i), 64'(m_valid), 64'd1);
            check($sformatf("bp_tdata c%0d", i),  64'(m_data),  64'h40400000);
            check($sformatf("bp_tuser c%0d", i),  64'(m_tag),   64'd1);
            check($sformatf("bp_s_ready c%0d", i), 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        drain("drain_bp");
        check("bp_out_count", 64'(out_count - oc), 64'd5);

        // Reset with three operations in flight
        m_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 8'h31, 32'h40400000, 4'b0000);
        issue(32'h3F800000, 32'h40400000, 8'h32, 32'h3EAAAAAB, 4'b0000);
        issue(32'h7F800000, 32'hC0000000, 8'h33, 32'hFF800000, 4'b0000);
        wait_valid("mid_rst_valid", n);
        aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_valid), 64'd0);
        check("mid_rst_tdata",  64'(m_data),  64'd0);
        check("mid_rst_tuser",  64'(m_tag),   64'd0);
        check("mid_rst_tflags", 64'(m_flags), 64'd0);
        sbq.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_ready = 1'b1;
        oc = out_count;
        repeat (60) @(posedge aclk);
        #1;
        check("no_stale_results", 64'(out_count - oc), 64'd0);
        check("post_rst_tvalid", 64'(m_valid), 64'd0);

        // Same scenarios on the 3-bits-per-stage instance
        run3(32'h40C00000, 32'h40000000, 8'h51, 32'h40400000, "bps3_6div2");
        run3(32'h3F800000, 32'h40400000, 8'h52, 32'h3EAAAAAB, "bps3_1div3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
